alu_mdu_seq: RTL and testbench

//  Parametrised execute unit: the full single-cycle ALU op set plus RV-M multiply/divide.
//  Ops are accepted over a valid/ready handshake and results are returned over a registered valid/ready output.
//  MUL/DIV are iterative (multi-cycle); ALU ops complete in 1 cycle. Sits in EX stage; pipeline stalls on IN_READY_o.

---
 rtl/alu_mdu_seq.sv | 217 +++++++++++++++++++++
 tb/tb_alu_mdu_seq.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mdu_seq.sv
// alu_mdu_seq: single-issue execute unit with 1-cycle ALU ops and iterative RV-M multiply/divide.
// One op in flight at a time; results are held in a registered output slot until taken.
module alu_mdu_seq #(
  parameter int WIDTH      = 32,
  parameter int MUL_UNROLL = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             FLUSH_i,
  input  logic             IN_VALID_i,
  output logic             IN_READY_o,
  input  logic [4:0]       OP_i,
  input  logic [WIDTH-1:0] RS1_i,
  input  logic [WIDTH-1:0] RS2_i,
  output logic             OUT_VALID_o,
  input  logic             OUT_READY_i,
  output logic [WIDTH-1:0] RD_o,
  output logic             ZERO_o
);
  localparam int SH_W      = $clog2(WIDTH);
  localparam int CNT_W     = SH_W + 1;
  localparam int MUL_STEPS = WIDTH / MUL_UNROLL;
  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_STEPS - 1);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t               state_reg, state_next;
  logic [2:0]           op_reg, op_next;
  logic [2*WIDTH-1:0]   work_reg, work_next;
  logic [WIDTH-1:0]     opb_reg, opb_next;
  logic                 neg_reg, neg_next;
  logic [CNT_W-1:0]     count_reg, count_next;
  logic [WIDTH-1:0]     rd_reg, rd_next;
  logic                 zero_reg, zero_next;
  logic                 out_valid_reg, out_valid_next;

  // ---------------- single-cycle ALU ----------------
  logic [SH_W-1:0]  shamt;
  logic [WIDTH-1:0] alu_res;

  assign shamt = RS2_i[SH_W-1:0];

  always_comb begin
    alu_res = RS1_i;
    case (OP_i[3:0])
      4'b0000: alu_res = RS1_i & RS2_i;
      4'b0001: alu_res = RS1_i | RS2_i;
      4'b0010: alu_res = RS1_i + RS2_i;
      4'b0011: alu_res = {{(WIDTH-1){1'b0}}, RS1_i == RS2_i};
      4'b0100: alu_res = RS1_i << shamt;
      4'b0101: alu_res = RS1_i >> shamt;
      4'b0111: alu_res = $signed(RS1_i) >>> shamt;
      4'b1000: alu_res = RS1_i ^ RS2_i;
      4'b1001: alu_res = ~(RS1_i | RS2_i);
      4'b1010: alu_res = RS1_i - RS2_i;
      4'b1100: alu_res = {{(WIDTH-1){1'b0}}, $signed(RS1_i) >= $signed(RS2_i)};
      4'b1101: alu_res = {{(WIDTH-1){1'b0}}, RS1_i >= RS2_i};
      4'b1110: alu_res = {{(WIDTH-1){1'b0}}, $signed(RS1_i) < $signed(RS2_i)};
      4'b1111: alu_res = {{(WIDTH-1){1'b0}}, RS1_i < RS2_i};
      default: alu_res = RS1_i;
    endcase
  end

  // ---------------- M-op operand preparation ----------------
  // The iterative datapaths work on magnitudes; the sign is reapplied on the final step.
  logic             a_signed, b_signed, a_neg, b_neg, div_by_zero, div_ovf;
  logic [WIDTH-1:0] a_mag, b_mag;

  assign a_signed    = OP_i[2] ? !OP_i[0] : (OP_i[1:0] == 2'b01 || OP_i[1:0] == 2'b10);
  assign b_signed    = OP_i[2] ? !OP_i[0] : (OP_i[1:0] == 2'b01);
  assign a_neg       = a_signed & RS1_i[WIDTH-1];
  assign b_neg       = b_signed & RS2_i[WIDTH-1];
  assign a_mag       = a_neg ? -RS1_i : RS1_i;
  assign b_mag       = b_neg ? -RS2_i : RS2_i;
  assign div_by_zero = (RS2_i == '0);
  assign div_ovf     = !OP_i[0] && (RS1_i == MIN_VAL) && (RS2_i == '1);

  // ---------------- multiply step: MUL_UNROLL shift-add bits per cycle ----------------
  // work_reg = {partial high, remaining multiplier}; each bit adds the multiplicand then shifts right.
  logic [2*WIDTH-1:0] mul_step;
  logic [WIDTH:0]     part_sum;

  always_comb begin
    mul_step = work_reg;
    part_sum = '0;
    for (int i = 0; i < MUL_UNROLL; i++) begin
      part_sum = {1'b0, mul_step[2*WIDTH-1:WIDTH]} + (mul_step[0] ? {1'b0, opb_reg} : '0);
      mul_step = {part_sum, mul_step[WIDTH-1:1]};
    end
  end

  // ---------------- restoring divide step: work_reg = {remainder, quotient} ----------------
  logic [WIDTH:0]       div_trial;
  logic [2*WIDTH-1:0]   div_step;

  assign div_trial = {work_reg[2*WIDTH-1:WIDTH], work_reg[WIDTH-1]} - {1'b0, opb_reg};
  assign div_step  = div_trial[WIDTH]
                   ? {work_reg[2*WIDTH-2:0], 1'b0}
                   : {div_trial[WIDTH-1:0], work_reg[WIDTH-2:0], 1'b1};

  logic [2*WIDTH-1:0] mul_fix;
  logic [WIDTH-1:0]   div_pick, div_fix;

  assign mul_fix  = neg_reg ? -mul_step : mul_step;
  assign div_pick = op_reg[1] ? div_step[2*WIDTH-1:WIDTH] : div_step[WIDTH-1:0];
  assign div_fix  = neg_reg ? -div_pick : div_pick;

  // ---------------- control ----------------
  logic             finish, no_zero;
  logic [WIDTH-1:0] result;

  always_comb begin
    state_next     = state_reg;
    op_next        = op_reg;
    work_next      = work_reg;
    opb_next       = opb_reg;
    neg_next       = neg_reg;
    count_next     = count_reg;
    rd_next        = rd_reg;
    zero_next      = zero_reg;
    out_valid_next = out_valid_reg;
    finish         = 1'b0;
    no_zero        = 1'b0;
    result         = '0;

    case (state_reg)
      S_IDLE: begin
        if (IN_VALID_i) begin
          op_next = OP_i[2:0];
          if (!OP_i[4]) begin
            finish  = 1'b1;
            result  = alu_res;
            no_zero = (OP_i[3:2] == 2'b01);
          end else if (OP_i[2] && div_by_zero) begin
            finish = 1'b1;
            result = OP_i[1] ? RS1_i : '1;
          end else if (OP_i[2] && div_ovf) begin
            finish = 1'b1;
            result = OP_i[1] ? '0 : MIN_VAL;
          end else begin
            state_next = S_BUSY;
            count_next = '0;
            neg_next   = (OP_i[2] && OP_i[1]) ? a_neg : (a_neg ^ b_neg);
            work_next  = {{WIDTH{1'b0}}, OP_i[2] ? a_mag : b_mag};
            opb_next   = OP_i[2] ? b_mag : a_mag;
          end
        end
      end
      S_BUSY: begin
        work_next  = op_reg[2] ? div_step : mul_step;
        count_next = count_reg + 1'b1;
        if (count_reg == (op_reg[2] ? DIV_LAST : MUL_LAST)) begin
          finish = 1'b1;
          if (op_reg[2])
            result = div_fix;
          else if (op_reg[1:0] == 2'b00)
            result = mul_fix[WIDTH-1:0];
          else
            result = mul_fix[2*WIDTH-1:WIDTH];
        end
      end
      S_DONE: begin
        if (OUT_READY_i) begin
          state_next     = S_IDLE;
          out_valid_next = 1'b0;
        end
      end
      default: state_next = S_IDLE;
    endcase

    if (finish) begin
      state_next     = S_DONE;
      rd_next        = result;
      zero_next      = (result == '0) && !no_zero;
      out_valid_next = 1'b1;
    end

    // Flush beats everything, including an accept in the same cycle.
    if (FLUSH_i) begin
      state_next     = S_IDLE;
      out_valid_next = 1'b0;
      rd_next        = rd_reg;
      zero_next      = zero_reg;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= S_IDLE;
      op_reg        <= '0;
      work_reg      <= '0;
      opb_reg       <= '0;
      neg_reg       <= 1'b0;
      count_reg     <= '0;
      rd_reg        <= '0;
      zero_reg      <= 1'b0;
      out_valid_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      op_reg        <= op_next;
      work_reg      <= work_next;
      opb_reg       <= opb_next;
      neg_reg       <= neg_next;
      count_reg     <= count_next;
      rd_reg        <= rd_next;
      zero_reg      <= zero_next;
      out_valid_reg <= out_valid_next;
    end
  end

  assign IN_READY_o  = (state_reg == S_IDLE) && !rst;
  assign OUT_VALID_o = out_valid_reg;
  assign RD_o        = rd_reg;
  assign ZERO_o      = zero_reg;
endmodule

// File: tb/tb_alu_mdu_seq.sv
// tb_alu_mdu_seq: directed and randomized checks of alu_mdu_seq against an arithmetic reference model.
// Covers latency, back-pressure, flush and asynchronous reset behaviour.
module tb_alu_mdu_seq;
  localparam logic [31:0] MIN32 = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  op;
  logic [31:0] rs1, rs2, rd;
  logic        out_valid, out_ready, zero;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  alu_mdu_seq #(.WIDTH(32), .MUL_UNROLL(4)) dut (
    .clk(clk), .rst(rst), .FLUSH_i(flush),
    .IN_VALID_i(in_valid), .IN_READY_o(in_ready), .OP_i(op),
    .RS1_i(rs1), .RS2_i(rs2),
    .OUT_VALID_o(out_valid), .OUT_READY_i(out_ready),
    .RD_o(rd), .ZERO_o(zero)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Reference result from plain integer arithmetic.
  function automatic logic [31:0] ref_rd(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b);
    int                sa, sb, sh;
    longint            pa, pb;
    longint unsigned   ua, ub;
    logic [63:0]       p;
    sa = a; sb = b; pa = sa; pb = sb; ua = a; ub = b; sh = int'(b[4:0]);
    if (!o[4]) begin
      case (o[3:0])
        4'd0:  return a & b;
        4'd1:  return a | b;
        4'd2:  return a + b;
        4'd3:  return (a == b) ? 32'd1 : 32'd0;
        4'd4:  return a << sh;
        4'd5:  return a >> sh;
        4'd7:  return 32'(sa >>> sh);
        4'd8:  return a ^ b;
        4'd9:  return ~(a | b);
        4'd10: return a - b;
        4'd12: return (sa >= sb) ? 32'd1 : 32'd0;
        4'd13: return (a >= b) ? 32'd1 : 32'd0;
        4'd14: return (sa < sb) ? 32'd1 : 32'd0;
        4'd15: return (a < b) ? 32'd1 : 32'd0;
        default: return a;
      endcase
    end
    case (o[2:0])
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = pa * pb; return p[63:32]; end
      3'd2: begin p = pa * longint'(ub); return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == MIN32 && b == 32'hFFFF_FFFF) return MIN32;
        return 32'(sa / sb);
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == MIN32 && b == 32'hFFFF_FFFF) return 32'd0;
        return 32'(sa % sb);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b);
    if (!o[4]) return 1;
    if (!o[2]) return 9;
    if (b == 0) return 1;
    if (!o[0] && a == MIN32 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // Issue one op, measure latency, check result, optionally hold back-pressure, then take it.
  task automatic run_op(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_rd, input int hold);
    int          lat;
    int          exp_lat;
    logic        exp_zero;
    exp_lat  = ref_lat(o, a, b);
    exp_zero = (exp_rd == 0) && (o[4:2] != 3'b001);
    @(negedge clk);
    for (int i = 0; i < 50 && !in_ready; i++) @(negedge clk);
    if (!in_ready) begin
      check("in_ready_wait", 32'(in_ready), 32'd1);
      return;
    end
    op = o; rs1 = a; rs2 = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; op = 5'($urandom); rs1 = $urandom; rs2 = $urandom;
    lat = 1;
    @(negedge clk);
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check("latency", 32'(lat), 32'(exp_lat));
    if (!out_valid) return;
    check("rd", rd, exp_rd);
    check("zero", 32'(zero), 32'(exp_zero));
    $display("op=%05b a=%08h b=%08h rd=%08h zero=%0d lat=%0d", o, a, b, rd, zero, lat);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_rd", rd, exp_rd);
      check("hold_zero", 32'(zero), 32'(exp_zero));
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    check("valid_drop", 32'(out_valid), 32'd0);
    check("ready_back", 32'(in_ready), 32'd1);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return MIN32;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [4:0]  o;
    logic [31:0] a, b;
    logic        seen;

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op = '0; rs1 = '0; rs2 = '0;
    repeat (3) @(negedge clk);
    check("reset_valid", 32'(out_valid), 32'd0);
    check("reset_rd", rd, 32'd0);
    check("reset_zero", 32'(zero), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("reset_in_ready", 32'(in_ready), 32'd1);

    // ALU directed
    run_op(5'b01010, 32'd5, 32'd7, 32'hFFFF_FFFE, 0);
    run_op(5'b00010, 32'd3, 32'hFFFF_FFFD, 32'd0, 0);
    run_op(5'b00100, 32'd1, 32'd33, 32'd2, 0);
    run_op(5'b00100, 32'd0, 32'd5, 32'd0, 0);
    run_op(5'b01110, 32'hFFFF_FFFF, 32'd1, 32'd1, 0);
    run_op(5'b01111, 32'hFFFF_FFFF, 32'd1, 32'd0, 0);
    // MUL directed
    run_op(5'b10001, MIN32, MIN32, 32'h4000_0000, 0);
    run_op(5'b10011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0);
    run_op(5'b10010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op(5'b10000, 32'd7, 32'd6, 32'd42, 0);
    // DIV directed, including the accept-time corner cases
    run_op(5'b10100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 0);
    run_op(5'b10110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 0);
    run_op(5'b10101, 32'd7, 32'd0, 32'hFFFF_FFFF, 0);
    run_op(5'b10111, 32'd7, 32'd0, 32'd7, 0);
    run_op(5'b10100, MIN32, 32'hFFFF_FFFF, MIN32, 0);
    run_op(5'b10110, MIN32, 32'hFFFF_FFFF, 32'd0, 0);
    // Back-pressure
    run_op(5'b01000, 32'h1234_5678, 32'h0F0F_0F0F, 32'h1D3B_5977, 5);
    run_op(5'b01010, 32'd9, 32'd9, 32'd0, 3);

    // Flush 10 cycles into a divide
    @(negedge clk);
    op = 5'b10101; rs1 = 32'd1000; rs2 = 32'd3; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    check("flush_in_ready", 32'(in_ready), 32'd1);
    check("flush_valid", 32'(out_valid), 32'd0);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("flush_no_result", 32'(seen), 32'd0);
    // Flush together with a request in IDLE: the op must not be accepted
    flush = 1'b1; in_valid = 1'b1; op = 5'b00000; rs1 = 32'hFF; rs2 = 32'hFF;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("flush_accept_ready", 32'(in_ready), 32'd1);
    check("flush_accept_valid", 32'(out_valid), 32'd0);
    run_op(5'b00000, 32'hF0, 32'h3C, 32'h30, 0);

    // Asynchronous reset in the middle of a multiply
    @(negedge clk);
    op = 5'b10011; rs1 = 32'hDEAD_BEEF; rs2 = 32'h1234_5678; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_valid", 32'(out_valid), 32'd0);
    check("arst_rd", rd, 32'd0);
    check("arst_zero", 32'(zero), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("arst_in_ready", 32'(in_ready), 32'd1);
    run_op(5'b10000, 32'h1234, 32'h10, 32'h0001_2340, 0);

    // Randomized ops against the reference model
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 1) == 1) o = {2'b10, 3'($urandom)};
      else                           o = {1'b0, 4'($urandom)};
      a = pick_operand();
      b = pick_operand();
      run_op(o, a, b, ref_rd(o, a, b), $urandom_range(0, 2));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
